vga_mem_arbiter: RTL

- Two-port Wishbone (pipelined) arbiter that shares the single video-memory bus between the display fetch engine (port 0, text/graphics driver) and a secondary requester (port 1, CPU-side blitter/DMA).
- Sits between the VGA master's outbus and the memory system.
- Port 0 has priority, with a fairness limit so port 1 is never starved.
- Bus ownership is held for a whole cyc tenure; outstanding pipelined reads are tracked so that grants never switch mid-transaction.

---
 rtl/vga_pkg.sv | 14 +
 rtl/if_wb.sv | 24 ++
 rtl/wb_outstanding_ctr.sv | 32 +++
 rtl/vga_mem_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types for the VGA video-memory bus arbiter.
package vga_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN0,
        ARB_OWN1
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone bundle, 32-bit address/data; dat_o/dat_i named from the master's side.
interface if_wb;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, sel, adr, dat_o,
        input  dat_i, ack, stall
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_o,
        output dat_i, ack, stall
    );

endinterface

// File: rtl/wb_outstanding_ctr.sv
// Tracks accepted-but-unacknowledged strobes; full flags the in-flight limit.
module wb_outstanding_ctr #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    assign full = (count == MAX_CNT);

    // Stray acks at zero are dropped rather than wrapping the count.
    always_ff @(posedge clk_i) begin
        if (!rst_i || clr) begin
            count <= '0;
        end else begin
            case ({inc && !full, dec && (count != '0)})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares the video-memory bus between display fetch (m0, priority) and a secondary
// requester (m1); ownership spans a whole cyc tenure, with a fairness cap on m0.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned FAIR_LIMIT = 4,
    parameter int unsigned MAX_OUT    = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    if_wb.slave        m0,
    if_wb.slave        m1,
    if_wb.master       outbus,
    output logic [1:0] grant
);

    localparam int unsigned          FAIR_W   = $clog2(FAIR_LIMIT + 1);
    localparam logic [FAIR_W-1:0]    FAIR_MAX = FAIR_W'(FAIR_LIMIT);

    arb_state_t        state_q, state_d;
    logic [FAIR_W-1:0] fair_q, fair_d;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_full;
    logic              own_cyc;
    logic              own_stb;
    logic              fwd_stb;
    logic              cnt_inc;
    logic              cnt_dec;
    logic              cnt_clr;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
            fair_q  <= '0;
        end else begin
            state_q <= state_d;
            fair_q  <= fair_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fair_d  = fair_q;
        case (state_q)
            ARB_IDLE: begin
                // m1 wins a contested slot only once m0 has used up its fairness quota.
                if (m0.cyc && (!m1.cyc || fair_q != FAIR_MAX)) begin
                    state_d = ARB_OWN0;
                    if (!m1.cyc)
                        fair_d = '0;
                    else if (fair_q != FAIR_MAX)
                        fair_d = fair_q + FAIR_W'(1);
                end else if (m1.cyc) begin
                    state_d = ARB_OWN1;
                    fair_d  = '0;
                end
            end
            ARB_OWN0: if (!m0.cyc) state_d = ARB_IDLE;
            ARB_OWN1: if (!m1.cyc) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        own_cyc      = 1'b0;
        own_stb      = 1'b0;
        outbus.we    = 1'b0;
        outbus.sel   = '0;
        outbus.adr   = '0;
        outbus.dat_o = '0;
        m0.dat_i     = '0;
        m0.ack       = 1'b0;
        m0.stall     = 1'b1;
        m1.dat_i     = '0;
        m1.ack       = 1'b0;
        m1.stall     = 1'b1;
        case (state_q)
            ARB_OWN0: begin
                own_cyc      = m0.cyc;
                own_stb      = m0.stb;
                outbus.we    = m0.we;
                outbus.sel   = m0.sel;
                outbus.adr   = m0.adr;
                outbus.dat_o = m0.dat_o;
                m0.dat_i     = outbus.dat_i;
                m0.ack       = outbus.ack && m0.cyc;
                m0.stall     = outbus.stall || out_full;
            end
            ARB_OWN1: begin
                own_cyc      = m1.cyc;
                own_stb      = m1.stb;
                outbus.we    = m1.we;
                outbus.sel   = m1.sel;
                outbus.adr   = m1.adr;
                outbus.dat_o = m1.dat_o;
                m1.dat_i     = outbus.dat_i;
                m1.ack       = outbus.ack && m1.cyc;
                m1.stall     = outbus.stall || out_full;
            end
            default: ;
        endcase
        fwd_stb    = own_cyc && own_stb && !out_full;
        outbus.cyc = own_cyc;
        outbus.stb = fwd_stb;
    end

    // Dropping cyc aborts the tenure, so anything still in flight is forgotten.
    assign cnt_inc = fwd_stb && !outbus.stall;
    assign cnt_dec = outbus.ack && own_cyc;
    assign cnt_clr = !own_cyc;

    wb_outstanding_ctr #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_out_ctr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .clr   (cnt_clr),
        .count (out_cnt),
        .full  (out_full)
    );

    assign grant = (state_q == ARB_OWN1) ? GRANT_M1 :
                   (state_q == ARB_OWN0) ? GRANT_M0 : GRANT_NONE;

endmodule
